wrfifo_shift_array: RTL and testbench
=====================================

Name: wrfifo_shift_array

Overview:
- Parametrised successor to the fixed 3-port / 4-bank write-FIFO array.
- Holds NUMVBNK independent compacting shift FIFOs, each WFFOCNT entries of WIDTH bits.
- Each bank accepts up to NUMWRPT pushes and up to NUMOUT pops per cycle.
- Each bank exposes its oldest NUMOUT entries as head ports to the bank write scheduler.
- Adds the following, which the fixed array left to external logic: occupancy tracking, full/almost-full flags, packed multi-push, sticky overflow/underflow error flags.

Parameters:
- WIDTH, 256, data bits per entry
- NUMWRPT, 3, write (push) ports per bank
- NUMVBNK, 4, number of virtual banks
- WFFOCNT, 16, entries per bank FIFO; must be >= NUMWRPT and >= NUMOUT
- NUMOUT, 2, head entries exposed (and max pops) per bank per cycle
- AFULL_THR, 13, fifo_afull asserts when count >= AFULL_THR
- localparam CNTW = $clog2(WFFOCNT+1)
- localparam PCW = $clog2(NUMOUT+1)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- push_vld  in  NUMVBNK*NUMWRPT  per-bank push valids; bit [b*NUMWRPT+p]
- push_dat  in  NUMVBNK*NUMWRPT*WIDTH  push data; same (b,p) ordering
- pop_cnt  in  NUMVBNK*PCW  entries popped from head this cycle, per bank
- head_dat  out  NUMVBNK*NUMOUT*WIDTH  head entry h of bank b at slot [b*NUMOUT+h]; h=0 oldest
- head_vld  out  NUMVBNK*NUMOUT  head slot holds a valid entry
- fifo_cnt  out  NUMVBNK*CNTW  occupancy per bank
- fifo_full  out  NUMVBNK  count == WFFOCNT
- fifo_afull  out  NUMVBNK  count >= AFULL_THR
- ovf_err  out  NUMVBNK  sticky: push dropped on full
- udf_err  out  NUMVBNK  sticky: pop_cnt exceeded count or NUMOUT

Behaviour:
- Interface (already decided): one clock, clk; reset rst_n is asynchronous and active-low.
- Reset: all counts 0, head_vld 0, head_dat 0, fifo_full 0, fifo_afull 0 (AFULL_THR > 0), ovf_err 0, udf_err 0. Entry storage is not reset.
- Reset mid-operation: all contents discarded immediately; first push after deassertion lands in entry 0.
- Per bank, per cycle, with cnt = current count:
  - pe (effective pops) = min(pop_cnt, cnt, NUMOUT).
  - udf_err sets if pop_cnt > cnt or pop_cnt > NUMOUT.
  - np = popcount of that bank's push_vld.
  - room = WFFOCNT - cnt + pe.
  - na (accepted pushes) = min(np, room); ovf_err sets if np > room.
  - Accepted pushes are the lowest-indexed valid ports; excess ports are dropped.
- Next entry i:
  - if i < cnt-pe: entry[i+pe] (shift toward head);
  - else if i < cnt-pe+na: push data of the (i-(cnt-pe))-th valid port, in ascending port order;
  - else hold.
- cnt_next = cnt - pe + na. It never exceeds WFFOCNT and never wraps.
- Latency:
  - Pushed data is visible on head_dat/head_vld one cycle after the push (registered).
  - Pop takes effect the same edge.
  - Push into a slot freed by a same-cycle pop is legal.
- head_vld[h] = (cnt > h). head_dat[h] = entry[h] when head_vld[h], else 0.
- fifo_cnt, fifo_full, fifo_afull are registered and derived from cnt.
- Banks are fully independent; no cross-bank interaction.
- ovf_err/udf_err clear only on reset.

Optional Feature:
- Macro: WRFIFO_BYPASS_EN.
- Defined: when a bank's cnt-pe < NUMOUT, accepted pushes are forwarded combinationally to head slots cnt-pe.. in the same cycle. Those slots have head_vld=1, head_dat=push data, computed against post-pop positions. The storage update is unchanged. pop_cnt must not pop bypassed data that same cycle; if it does, udf_err sets.
- Undefined: heads are purely registered; push-to-head latency is 1 cycle.

Test Plan:
- Reset, then bank0 push_vld=3'b101 with data A (port0), C (port2) -> next cycle cnt=2, head_dat[0]=A, head_dat[1]=C, head_vld=2'b11; other banks cnt=0.
- Fill bank1 to 16, then pop_cnt=1 with push_vld=3'b111 -> port0 accepted into entry 15, ports 1-2 dropped; ovf_err[1]=1, cnt=16, fifo_full[1]=1.
- Bank2 cnt=1 (entry X), pop_cnt=2 -> cnt=0, udf_err[2]=1, head_vld[2*]=0, head_dat=0.
- Bank3 cnt=5 (E0..E4), pop_cnt=2 plus push D0,D1 -> next cnt=5, order E2,E3,E4,D0,D1; head_dat=E2,E3.
- cnt reaching 13 -> fifo_afull=1; drops to 12 -> 0. Assert rst_n low mid-burst -> all outputs 0 asynchronously, without waiting for a clock edge.
- With WRFIFO_BYPASS_EN, bank0 empty, push A -> head_dat[0]=A and head_vld[0]=1 in the same cycle; next cycle cnt=1, head_dat[0]=A.

Source files
------------

// File: rtl/wrfifo_shift_array.sv
// wrfifo_shift_array: NUMVBNK independent compacting shift FIFOs.
// Each bank takes up to NUMWRPT pushes and NUMOUT pops per cycle. It shows
// its oldest NUMOUT entries as head slots. Per bank it also provides an
// occupancy count, full and almost-full flags, and sticky overflow and
// underflow error flags.
// Optional feature macro: WRFIFO_BYPASS_EN. When it is defined, accepted
// pushes are also forwarded combinationally into empty head slots.
module wrfifo_shift_array #(
  parameter int WIDTH     = 256,
  parameter int NUMWRPT   = 3,
  parameter int NUMVBNK   = 4,
  parameter int WFFOCNT   = 16,
  parameter int NUMOUT    = 2,
  parameter int AFULL_THR = 13,
  localparam int CNTW = $clog2(WFFOCNT+1),
  localparam int PCW  = $clog2(NUMOUT+1)
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [NUMVBNK*NUMWRPT-1:0]         push_vld,
  input  logic [NUMVBNK*NUMWRPT*WIDTH-1:0]   push_dat,
  input  logic [NUMVBNK*PCW-1:0]             pop_cnt,
  output logic [NUMVBNK*NUMOUT*WIDTH-1:0]    head_dat,
  output logic [NUMVBNK*NUMOUT-1:0]          head_vld,
  output logic [NUMVBNK*CNTW-1:0]            fifo_cnt,
  output logic [NUMVBNK-1:0]                 fifo_full,
  output logic [NUMVBNK-1:0]                 fifo_afull,
  output logic [NUMVBNK-1:0]                 ovf_err,
  output logic [NUMVBNK-1:0]                 udf_err
);

  // Smaller of two integers.
  function automatic int min2(input int a, input int b);
    if (a < b) begin
      return a;
    end else begin
      return b;
    end
  endfunction

  // Number of asserted push valids for one bank.
  function automatic int popcnt(input logic [NUMWRPT-1:0] v);
    int n;
    n = 0;
    for (int p = 0; p < NUMWRPT; p++) begin
      if (v[p]) begin
        n++;
      end else begin
        n = n;
      end
    end
    return n;
  endfunction

  logic [CNTW-1:0]   cnt_r      [NUMVBNK];
  logic [CNTW-1:0]   cnt_nxt_s  [NUMVBNK];
  logic [WIDTH-1:0]  mem_r      [NUMVBNK][WFFOCNT];
  logic [WIDTH-1:0]  mem_nxt_s  [NUMVBNK][WFFOCNT];
  // Accepted pushes are packed into the low slots, in ascending port order.
  logic [WIDTH-1:0]  acc_dat_s  [NUMVBNK][NUMWRPT];

  logic [NUMVBNK*NUMOUT*WIDTH-1:0] head_dat_r, head_dat_nxt_s;
  logic [NUMVBNK*NUMOUT-1:0]       head_vld_r, head_vld_nxt_s;
  logic [NUMVBNK-1:0] full_r, full_nxt_s, afull_r, afull_nxt_s;
  logic [NUMVBNK-1:0] ovf_r, ovf_set_s, udf_r, udf_set_s;

`ifdef WRFIFO_BYPASS_EN
  int keep_s [NUMVBNK];
  int na_s   [NUMVBNK];
`endif

  // Per-bank pop/push arithmetic, shifted storage image and next flag values.
  always_comb begin
    int cnt, pc, pe, np, room, na, keep, nxt, k;
    mem_nxt_s      = mem_r;
    head_dat_nxt_s = '0;
    head_vld_nxt_s = '0;
    full_nxt_s     = '0;
    afull_nxt_s    = '0;
    ovf_set_s      = '0;
    udf_set_s      = '0;
    for (int b = 0; b < NUMVBNK; b++) begin
      cnt  = int'(cnt_r[b]);
      pc   = int'(pop_cnt[b*PCW +: PCW]);
      pe   = min2(min2(pc, cnt), NUMOUT);
      udf_set_s[b] = (pc > cnt) || (pc > NUMOUT);
      np   = popcnt(push_vld[b*NUMWRPT +: NUMWRPT]);
      room = WFFOCNT - cnt + pe;
      na   = min2(np, room);
      ovf_set_s[b] = (np > room);
      keep = cnt - pe;
      nxt  = keep + na;
`ifdef WRFIFO_BYPASS_EN
      keep_s[b] = keep;
      na_s[b]   = na;
`endif
      // Keep the lowest-indexed valid ports. Drop the rest.
      for (int p = 0; p < NUMWRPT; p++) begin
        acc_dat_s[b][p] = '0;
      end
      k = 0;
      for (int p = 0; p < NUMWRPT; p++) begin
        if (push_vld[b*NUMWRPT+p] && (k < na)) begin
          acc_dat_s[b][k] = push_dat[(b*NUMWRPT+p)*WIDTH +: WIDTH];
          k++;
        end else begin
          k = k;
        end
      end
      // Survivors shift toward the head. Accepted pushes land right after them.
      for (int i = 0; i < WFFOCNT; i++) begin
        if (i < keep) begin
          mem_nxt_s[b][i] = mem_r[b][i+pe];
        end else if (i < nxt) begin
          mem_nxt_s[b][i] = acc_dat_s[b][i-keep];
        end else begin
          mem_nxt_s[b][i] = mem_r[b][i];
        end
      end
      cnt_nxt_s[b]   = CNTW'(nxt);
      full_nxt_s[b]  = (nxt == WFFOCNT);
      afull_nxt_s[b] = (nxt >= AFULL_THR);
      // Head slots are registered from the next storage image. Empty slots read 0.
      for (int h = 0; h < NUMOUT; h++) begin
        if (nxt > h) begin
          head_vld_nxt_s[b*NUMOUT+h]                 = 1'b1;
          head_dat_nxt_s[(b*NUMOUT+h)*WIDTH +: WIDTH] = mem_nxt_s[b][h];
        end else begin
          head_vld_nxt_s[b*NUMOUT+h]                 = 1'b0;
          head_dat_nxt_s[(b*NUMOUT+h)*WIDTH +: WIDTH] = '0;
        end
      end
    end
  end

  // Control state: counts, head registers, flags and sticky errors.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < NUMVBNK; b++) begin
        cnt_r[b] <= '0;
      end
      head_dat_r <= '0;
      head_vld_r <= '0;
      full_r     <= '0;
      afull_r    <= '0;
      ovf_r      <= '0;
      udf_r      <= '0;
    end else begin
      for (int b = 0; b < NUMVBNK; b++) begin
        cnt_r[b] <= cnt_nxt_s[b];
      end
      head_dat_r <= head_dat_nxt_s;
      head_vld_r <= head_vld_nxt_s;
      full_r     <= full_nxt_s;
      afull_r    <= afull_nxt_s;
      ovf_r      <= ovf_r | ovf_set_s;
      udf_r      <= udf_r | udf_set_s;
    end
  end

  // Entry storage has no reset; count and head_vld qualify its contents.
  always_ff @(posedge clk) begin
    for (int b = 0; b < NUMVBNK; b++) begin
      for (int i = 0; i < WFFOCNT; i++) begin
        mem_r[b][i] <= mem_nxt_s[b][i];
      end
    end
  end

  // Pack the per-bank counts onto the output bus.
  always_comb begin
    fifo_cnt = '0;
    for (int b = 0; b < NUMVBNK; b++) begin
      fifo_cnt[b*CNTW +: CNTW] = cnt_r[b];
    end
  end

  assign fifo_full  = full_r;
  assign fifo_afull = afull_r;
  assign ovf_err    = ovf_r;
  assign udf_err    = udf_r;

  // Head outputs. With bypass enabled, same-cycle pushes overlay post-pop slots.
  always_comb begin
    head_dat = head_dat_r;
    head_vld = head_vld_r;
`ifdef WRFIFO_BYPASS_EN
    for (int b = 0; b < NUMVBNK; b++) begin
      for (int h = 0; h < NUMOUT; h++) begin
        if ((h >= keep_s[b]) && (h < keep_s[b] + na_s[b])) begin
          head_vld[b*NUMOUT+h]                 = 1'b1;
          head_dat[(b*NUMOUT+h)*WIDTH +: WIDTH] = acc_dat_s[b][h-keep_s[b]];
        end else begin
          head_vld[b*NUMOUT+h]                 = head_vld_r[b*NUMOUT+h];
          head_dat[(b*NUMOUT+h)*WIDTH +: WIDTH] = head_dat_r[(b*NUMOUT+h)*WIDTH +: WIDTH];
        end
      end
    end
`endif
  end

endmodule

// File: tb/tb_wrfifo_shift_array.sv
// Bench for wrfifo_shift_array in its default (registered-head) build.
// It uses a queue-based reference model, a directed vector table, hand-written
// corner sequences and randomized traffic.
module tb_wrfifo_shift_array;
  localparam int W  = 256;
  localparam int P  = 3;
  localparam int B  = 4;
  localparam int D  = 16;
  localparam int O  = 2;
  localparam int AF = 13;
  localparam int CW = $clog2(D+1);
  localparam int PW = $clog2(O+1);

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [B*P-1:0]    push_vld;
  logic [B*P*W-1:0]  push_dat;
  logic [B*PW-1:0]   pop_cnt;
  logic [B*O*W-1:0]  head_dat;
  logic [B*O-1:0]    head_vld;
  logic [B*CW-1:0]   fifo_cnt;
  logic [B-1:0]      fifo_full, fifo_afull, ovf_err, udf_err;

  wrfifo_shift_array dut (
    .clk(clk), .rst_n(rst_n), .push_vld(push_vld), .push_dat(push_dat),
    .pop_cnt(pop_cnt), .head_dat(head_dat), .head_vld(head_vld),
    .fifo_cnt(fifo_cnt), .fifo_full(fifo_full), .fifo_afull(fifo_afull),
    .ovf_err(ovf_err), .udf_err(udf_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Reference model: one queue per bank, index 0 is the oldest entry.
  logic [W-1:0] mq [B][$];
  bit           m_ovf [B];
  bit           m_udf [B];

  typedef struct {
    logic [2:0] pv;
    int         t0, t1, t2;
    logic [1:0] pop;
    int         e_cnt;
    logic [1:0] e_vld;
    int         e_h0, e_h1;
    bit         e_udf;
  } vec_t;
  vec_t tbl [6];

  function automatic void chk(string nm, int b, logic [W-1:0] act, logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s bank%0d act=%h exp=%h", nm, b, act, exp);
    end
  endfunction

  function automatic logic [W-1:0] tagd(int t);
    return {8{t}};
  endfunction

  function automatic logic [W-1:0] rnd();
    logic [W-1:0] r;
    for (int k = 0; k < W/32; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic int cnt_of(int b);
    return int'(fifo_cnt[b*CW +: CW]);
  endfunction

  function automatic logic [W-1:0] hd(int b, int h);
    return head_dat[(b*O+h)*W +: W];
  endfunction

  function automatic void model_reset();
    for (int b = 0; b < B; b++) begin
      mq[b].delete();
      m_ovf[b] = 1'b0;
      m_udf[b] = 1'b0;
    end
  endfunction

  function automatic void model_step();
    for (int b = 0; b < B; b++) begin
      int cnt = mq[b].size();
      int pc  = int'(pop_cnt[b*PW +: PW]);
      if (pc > cnt || pc > O) m_udf[b] = 1'b1;
      for (int n = 0; n < pc && n < O && mq[b].size() > 0; n++) void'(mq[b].pop_front());
      for (int p = 0; p < P; p++) begin
        if (push_vld[b*P+p]) begin
          if (mq[b].size() < D) mq[b].push_back(push_dat[(b*P+p)*W +: W]);
          else m_ovf[b] = 1'b1;
        end
      end
    end
  endfunction

  function automatic void check_all();
    for (int b = 0; b < B; b++) begin
      int sz = mq[b].size();
      chk("cnt",   b, W'(cnt_of(b)),    W'(sz));
      chk("full",  b, W'(fifo_full[b]),  W'(sz == D));
      chk("afull", b, W'(fifo_afull[b]), W'(sz >= AF));
      chk("ovf",   b, W'(ovf_err[b]),    W'(m_ovf[b]));
      chk("udf",   b, W'(udf_err[b]),    W'(m_udf[b]));
      for (int h = 0; h < O; h++) begin
        chk("hvld", b, W'(head_vld[b*O+h]), W'(sz > h));
        chk("hdat", b, hd(b, h), (sz > h) ? mq[b][h] : '0);
      end
    end
  endfunction

  task automatic clear_in();
    push_vld = '0;
    push_dat = '0;
    pop_cnt  = '0;
  endtask

  task automatic set_bank(int b, logic [2:0] pv, logic [W-1:0] d0, logic [W-1:0] d1,
                          logic [W-1:0] d2, logic [1:0] pop);
    push_vld[b*P +: P]      = pv;
    push_dat[(b*P)*W +: W]   = d0;
    push_dat[(b*P+1)*W +: W] = d1;
    push_dat[(b*P+2)*W +: W] = d2;
    pop_cnt[b*PW +: PW]     = pop;
  endtask

  // One clock: the model advances at the edge, outputs are compared 1 time unit later.
  task automatic cyc();
    @(posedge clk);
    if (rst_n) model_step();
    #1;
    check_all();
  endtask

  // Reset between clock edges; outputs must clear with no clock edge.
  task automatic do_async_reset();
    clear_in();
    rst_n = 1'b0;
    model_reset();
    #2;
    check_all();
    chk("rst_vld", 0, W'(head_vld), '0);
    chk("rst_cnt", 0, W'(fifo_cnt), '0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [W-1:0] d_new;
    tbl[0] = '{3'b101, 32'hA,  32'h0,  32'hC,  2'd0, 2, 2'b11, 32'hA,  32'hC,  1'b0};
    tbl[1] = '{3'b010, 32'h0,  32'hB,  32'h0,  2'd1, 2, 2'b11, 32'hC,  32'hB,  1'b0};
    tbl[2] = '{3'b111, 32'h11, 32'h12, 32'h13, 2'd2, 3, 2'b11, 32'h11, 32'h12, 1'b0};
    tbl[3] = '{3'b000, 32'h0,  32'h0,  32'h0,  2'd3, 1, 2'b01, 32'h13, 32'h0,  1'b1};
    tbl[4] = '{3'b000, 32'h0,  32'h0,  32'h0,  2'd2, 0, 2'b00, 32'h0,  32'h0,  1'b1};
    tbl[5] = '{3'b100, 32'h0,  32'h0,  32'h21, 2'd0, 1, 2'b01, 32'h21, 32'h0,  1'b1};

    clear_in();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table on bank 0.
    for (int i = 0; i < 6; i++) begin
      clear_in();
      set_bank(0, tbl[i].pv, tagd(tbl[i].t0), tagd(tbl[i].t1), tagd(tbl[i].t2), tbl[i].pop);
      cyc();
      chk("tbl_cnt", 0, W'(cnt_of(0)), W'(tbl[i].e_cnt));
      chk("tbl_vld", 0, W'(head_vld[1:0]), W'(tbl[i].e_vld));
      chk("tbl_h0",  0, hd(0, 0), (tbl[i].e_h0 == 0) ? '0 : tagd(tbl[i].e_h0));
      chk("tbl_h1",  0, hd(0, 1), (tbl[i].e_h1 == 0) ? '0 : tagd(tbl[i].e_h1));
      chk("tbl_udf", 0, W'(udf_err[0]), W'(tbl[i].e_udf));
      chk("tbl_b1_cnt", 1, W'(cnt_of(1)), '0);
    end

    // Bank 3: pop two while pushing two, compaction order.
    clear_in(); set_bank(3, 3'b111, tagd(32'hE0), tagd(32'hE1), tagd(32'hE2), 2'd0); cyc();
    clear_in(); set_bank(3, 3'b011, tagd(32'hE3), tagd(32'hE4), '0, 2'd0); cyc();
    chk("b3_cnt5", 3, W'(cnt_of(3)), W'(5));
    clear_in(); set_bank(3, 3'b011, tagd(32'hD0), tagd(32'hD1), '0, 2'd2); cyc();
    chk("b3_cnt", 3, W'(cnt_of(3)), W'(5));
    chk("b3_h0", 3, hd(3, 0), tagd(32'hE2));
    chk("b3_h1", 3, hd(3, 1), tagd(32'hE3));
    clear_in(); set_bank(3, 3'b000, '0, '0, '0, 2'd2); cyc();
    chk("b3_h0b", 3, hd(3, 0), tagd(32'hE4));
    chk("b3_h1b", 3, hd(3, 1), tagd(32'hD0));
    clear_in(); set_bank(3, 3'b000, '0, '0, '0, 2'd2); cyc();
    chk("b3_h0c", 3, hd(3, 0), tagd(32'hD1));
    chk("b3_vldc", 3, W'(head_vld[7:6]), W'(2'b01));

    // Bank 1: afull threshold, full, overflow with a same-cycle pop.
    for (int i = 0; i < 4; i++) begin
      clear_in(); set_bank(1, 3'b111, rnd(), rnd(), rnd(), 2'd0); cyc();
    end
    chk("b1_cnt12", 1, W'(cnt_of(1)), W'(12));
    chk("b1_afull12", 1, W'(fifo_afull[1]), '0);
    clear_in(); set_bank(1, 3'b001, rnd(), rnd(), rnd(), 2'd0); cyc();
    chk("b1_afull13", 1, W'(fifo_afull[1]), W'(1));
    clear_in(); set_bank(1, 3'b111, rnd(), rnd(), rnd(), 2'd0); cyc();
    chk("b1_full", 1, W'(fifo_full[1]), W'(1));
    chk("b1_ovf0", 1, W'(ovf_err[1]), '0);
    d_new = rnd();
    clear_in(); set_bank(1, 3'b111, d_new, rnd(), rnd(), 2'd1); cyc();
    chk("b1_ovf", 1, W'(ovf_err[1]), W'(1));
    chk("b1_cnt16", 1, W'(cnt_of(1)), W'(16));
    chk("b1_full2", 1, W'(fifo_full[1]), W'(1));
    clear_in(); set_bank(1, 3'b000, '0, '0, '0, 2'd2); cyc();
    clear_in(); set_bank(1, 3'b000, '0, '0, '0, 2'd1); cyc();
    chk("b1_afull13b", 1, W'(fifo_afull[1]), W'(1));
    clear_in(); set_bank(1, 3'b000, '0, '0, '0, 2'd1); cyc();
    chk("b1_afull12b", 1, W'(fifo_afull[1]), '0);
    for (int i = 0; i < 5; i++) begin
      clear_in(); set_bank(1, 3'b000, '0, '0, '0, 2'd2); cyc();
    end
    chk("b1_kept", 1, hd(1, 1), d_new);

    // Bank 2: pop more than held.
    clear_in(); set_bank(2, 3'b001, tagd(32'h58), '0, '0, 2'd0); cyc();
    clear_in(); set_bank(2, 3'b000, '0, '0, '0, 2'd2); cyc();
    chk("b2_cnt", 2, W'(cnt_of(2)), '0);
    chk("b2_udf", 2, W'(udf_err[2]), W'(1));
    chk("b2_vld", 2, W'(head_vld[5:4]), '0);
    chk("b2_h0", 2, hd(2, 0), '0);

    // Reset mid-burst, then the first push lands at the head.
    for (int i = 0; i < 3; i++) begin
      clear_in();
      for (int b = 0; b < B; b++) set_bank(b, 3'b111, rnd(), rnd(), rnd(), 2'd1);
      cyc();
    end
    do_async_reset();
    clear_in(); set_bank(0, 3'b010, '0, tagd(32'h77), '0, 2'd0); cyc();
    chk("rst_first", 0, hd(0, 0), tagd(32'h77));
    chk("rst_first_cnt", 0, W'(cnt_of(0)), W'(1));

    // Randomized traffic, alternating fill-biased and drain-biased phases.
    for (int c = 0; c < 2000; c++) begin
      bit drain;
      logic [2:0] pv;
      logic [1:0] pop;
      drain = ((c / 150) % 2) == 1;
      clear_in();
      for (int b = 0; b < B; b++) begin
        pv  = drain ? 3'($urandom & $urandom) : 3'($urandom_range(0, 7));
        pop = drain ? 2'($urandom_range(1, 2)) : 2'($urandom_range(0, 1));
        if ($urandom_range(0, 49) == 0) pop = 2'd3;
        set_bank(b, pv, rnd(), rnd(), rnd(), pop);
      end
      cyc();
      if (c == 1000) do_async_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
